button_selector: RTL and testbench

Parametrised, registered front-end for the menu/game push-buttons. It conditions N raw asynchronous button inputs with a two-flop synchroniser and a per-button debounce counter. It emits a one-cycle press pulse per accepted press, with lowest-index priority and an optional hold-to-auto-repeat mode. It sits between the board button pins and the menu/selection FSMs, and generalises the two-button next/select registering stage.

---
 rtl/button_selector.sv | 138 +++++++++++++
 tb/tb_button_selector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/button_selector.sv
// Purpose: synchronise, debounce and prioritise N push-buttons into one-cycle press/auto-repeat pulses.
// Latency: raw rise to press pulse is 3+DEBOUNCE_CYCLES clock edges; all outputs registered.
// Backpressure: none; presses while enable=0 or losing priority are dropped, never queued.
module button_selector #(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 4,
    localparam int CODE_W = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] pulse,
    output logic [N_BUTTONS-1:0] held,
    output logic [CODE_W-1:0]    code,
    output logic                 repeat_flag
);

    localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [N_BUTTONS-1:0] s1;
    logic [N_BUTTONS-1:0] s2;
    logic [N_BUTTONS-1:0] stable;
    logic [N_BUTTONS-1:0] stable_d;
    logic [DCW-1:0]       dcnt [N_BUTTONS];

    logic [N_BUTTONS-1:0] press;
    logic                 sel_vld;
    logic [CODE_W-1:0]    sel_idx;

    state_t               state;
    logic [CODE_W-1:0]    owner;
    logic [RCW-1:0]       rcnt;
    logic                 owner_held;
    logic [RCW-1:0]       rcnt_target;

    // Two-flop synchroniser, per-button debounce counter and one-cycle-delayed stable copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            s1       <= buttons;
            s2       <= s1;
            stable_d <= stable;
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (s2[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
                    // Level has disagreed for DEBOUNCE_CYCLES consecutive cycles: accept it.
                    stable[i] <= s2[i];
                    dcnt[i]   <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DCW'(1);
                end
            end
        end
    end

    assign held  = stable;
    assign press = stable & ~stable_d;

    // Lowest-index press wins; simultaneous higher-index presses are simply ignored.
    always_comb begin
        sel_vld = |press;
        sel_idx = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (press[i]) begin
                sel_idx = CODE_W'(i);
            end
        end
    end

    assign owner_held  = stable[owner];
    assign rcnt_target = (state == ST_DELAY) ? RCW'(REPEAT_DELAY) : RCW'(REPEAT_PERIOD);

    // Repeat FSM with registered pulse/code/repeat_flag; a fresh press always pre-empts a pending repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= '0;
            rcnt        <= '0;
            pulse       <= '0;
            code        <= '0;
            repeat_flag <= 1'b0;
        end else begin
            pulse       <= '0;
            code        <= '0;
            repeat_flag <= 1'b0;
            if (enable && sel_vld) begin
                pulse <= N_BUTTONS'(1) << sel_idx;
                code  <= sel_idx;
                owner <= sel_idx;
                rcnt  <= RCW'(1);
                state <= (REPEAT_EN != 0) ? ST_DELAY : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (!enable || !owner_held) begin
                            state <= ST_IDLE;
                        end else if (rcnt == rcnt_target) begin
                            pulse       <= N_BUTTONS'(1) << owner;
                            code        <= owner;
                            repeat_flag <= 1'b1;
                            rcnt        <= RCW'(1);
                            state       <= ST_REPEAT;
                        end else begin
                            rcnt <= rcnt + RCW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_selector.sv
// Purpose: randomized plus directed stimulus for button_selector against a window/arithmetic reference model.
// Latency: model predicts outputs after every posedge; DUT sampled on the following negedge.
// Backpressure: not applicable.
module tb_button_selector;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] buttons = 4'h0;
    logic [3:0] pulse;
    logic [3:0] held;
    logic [1:0] code;
    logic       repeat_flag;

    always #5 clk = ~clk;

    button_selector #(
        .N_BUTTONS       (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .buttons     (buttons),
        .pulse       (pulse),
        .held        (held),
        .code        (code),
        .repeat_flag (repeat_flag)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state: raw sample history, synchronised-level window, press bookkeeping.
    logic [3:0] rawq[$];
    logic [3:0] wq[$];
    logic [3:0] st_now, st_old;
    logic [3:0] e_pulse, e_held;
    logic [1:0] e_code;
    logic       e_rep;
    bit         m_active;
    int         m_owner, m_tp, t;
    int         first_pulse;

    task automatic model_reset();
        rawq.delete();
        wq.delete();
        for (int i = 0; i < 3; i++) rawq.push_back(4'h0);
        for (int i = 0; i < D; i++) wq.push_back(4'h0);
        st_now = '0; st_old = '0;
        e_pulse = '0; e_held = '0; e_code = '0; e_rep = 1'b0;
        m_active = 1'b0; m_owner = 0; m_tp = 0; t = 0;
        first_pulse = -1;
    endtask

    task automatic model_step(input logic [3:0] b, input logic en);
        logic [3:0] prs, s2in, nst;
        int         d;
        bit         all_diff;
        t++;
        prs = st_now & ~st_old;
        e_pulse = '0; e_code = '0; e_rep = 1'b0;
        if (en && prs != 4'h0) begin
            int k = 0;
            for (int i = N - 1; i >= 0; i--) if (prs[i]) k = i;
            e_pulse  = 4'h1 << k;
            e_code   = 2'(k);
            m_active = 1'b1;
            m_owner  = k;
            m_tp     = t;
        end else if (m_active) begin
            if (!en || !st_now[m_owner]) begin
                m_active = 1'b0;
            end else begin
                d = t - m_tp;
                if (d == RD || (d > RD && (d - RD) % RP == 0)) begin
                    e_pulse = 4'h1 << m_owner;
                    e_code  = 2'(m_owner);
                    e_rep   = 1'b1;
                end
            end
        end
        // Synchronised level seen by the debouncer is the raw sample two edges back.
        rawq.push_front(b);
        void'(rawq.pop_back());
        s2in = rawq[2];
        wq.push_front(s2in);
        void'(wq.pop_back());
        nst = st_now;
        for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (wq[j][i] == st_now[i]) all_diff = 1'b0;
            if (all_diff) nst[i] = ~st_now[i];
        end
        st_old = st_now;
        st_now = nst;
        e_held = nst;
    endtask

    task automatic cycle(input logic [3:0] b, input logic en);
        buttons = b;
        enable  = en;
        @(posedge clk);
        model_step(b, en);
        @(negedge clk);
        chk("pulse", 32'(pulse), 32'(e_pulse));
        chk("held", 32'(held), 32'(e_held));
        chk("code", 32'(code), 32'(e_code));
        chk("repeat_flag", 32'(repeat_flag), 32'(e_rep));
        if (pulse != 4'h0 && first_pulse < 0) first_pulse = t;
    endtask

    task automatic do_reset(input logic [3:0] b);
        buttons = b;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_held", 32'(held), 32'h0);
        chk("rst_code", 32'(code), 32'h0);
        chk("rst_repeat_flag", 32'(repeat_flag), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rb;
        logic       ren;

        // Reset with all buttons high, then lowest index wins at edge 7.
        do_reset(4'hF);
        repeat (20) cycle(4'hF, 1'b1);
        chk("first_press_edge", 32'(first_pulse), 32'd7);
        repeat (12) cycle(4'h0, 1'b1);

        // Bounce on button 1: 3 high / 1 low, then steady high.
        for (int i = 0; i < 20; i++) cycle((i % 4 != 3) ? 4'h2 : 4'h0, 1'b1);
        repeat (15) cycle(4'h2, 1'b1);
        repeat (12) cycle(4'h0, 1'b1);

        // Simultaneous rise of buttons 3 and 2.
        repeat (20) cycle(4'hC, 1'b1);
        repeat (12) cycle(4'h0, 1'b1);

        // Press completes debounce while masked; no late replay.
        repeat (10) cycle(4'h1, 1'b0);
        repeat (10) cycle(4'h1, 1'b1);
        repeat (12) cycle(4'h0, 1'b1);

        // Long hold for auto-repeat, then release.
        repeat (48) cycle(4'h1, 1'b1);
        repeat (14) cycle(4'h0, 1'b1);

        // Pre-emption of a repeating owner by button 2.
        repeat (24) cycle(4'h1, 1'b1);
        repeat (24) cycle(4'h5, 1'b1);
        repeat (12) cycle(4'h0, 1'b1);

        // Reset while button 0 is physically held: re-debounce from zero.
        repeat (5) cycle(4'h1, 1'b1);
        do_reset(4'h1);
        repeat (20) cycle(4'h1, 1'b1);
        chk("repress_after_reset_edge", 32'(first_pulse), 32'd7);
        repeat (12) cycle(4'h0, 1'b1);

        // Random button activity with occasional enable drops.
        rb = 4'h0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
            ren = ($urandom_range(0, 15) != 0);
            cycle(rb, ren);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
